// File: rtl/conv_col_sequencer.sv
// Sequences column-buffer BRAM writes/reads, bank rotation and convolver valid timing.
// Latency: write strobe 1 cycle after i_valid; first o_conv_valid 1+RD_LAT cycles after the SoP edge.
// Backpressure: none; reads stream one address per cycle, and pixels arriving in RUN/DONE are dropped.
module conv_col_sequencer #(
  parameter int ADDR_W  = 11,
  parameter int N_BANKS = 4,
  parameter int RD_LAT  = 2
) (
  input  logic                       i_CLK,
  input  logic                       i_rst,
  input  logic                       i_valid,
  input  logic [ADDR_W-1:0]          i_imgLength,
  input  logic                       i_SoP,
  output logic [N_BANKS-1:0]         o_wr_en,
  output logic [ADDR_W-1:0]          o_wr_addr,
  output logic [ADDR_W-1:0]          o_rd_addr,
  output logic [$clog2(N_BANKS)-1:0] o_bank_ptr,
  output logic                       o_conv_valid,
  output logic                       o_EoP,
  output logic                       o_err,
  output logic [1:0]                 o_state
);

  localparam int BW = $clog2(N_BANKS);
  localparam int CW = $clog2(N_BANKS + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   len_q;
  logic [ADDR_W-1:0]   wr_cnt_q;
  logic [ADDR_W-1:0]   rd_cnt_q;
  logic [BW-1:0]       bank_q;
  logic [CW-1:0]       cols_q;
  logic [N_BANKS-1:0]  wr_en_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  // vld_q[0] is aligned with o_rd_addr; vld_q[RD_LAT] is data arriving at the convolver
  logic [RD_LAT:0]     vld_q;
  logic                err_q;
  logic                eop_q;

  logic                wr_fire;
  logic                wr_last;
  logic                rd_fire;
  logic                run_last;
  logic                err_set;
  logic [ADDR_W-1:0]   eff_len;
  logic [N_BANKS-1:0]  onehot;

  // State register
  always_ff @(posedge i_CLK) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode plus the per-cycle write/read/terminate strobes
  always_comb begin
    state_d  = state_q;
    wr_fire  = 1'b0;
    rd_fire  = 1'b0;
    run_last = 1'b0;
    err_set  = 1'b0;
    // The first pixel is compared against the live length, since len_q latches on that same edge
    eff_len  = len_q;
    case (state_q)
      S_IDLE: begin
        eff_len = i_imgLength;
        if (i_valid && (i_imgLength != '0)) begin
          wr_fire = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        wr_fire = i_valid;
        if (i_SoP) begin
          if (cols_q >= CW'(3)) begin
            state_d = S_RUN;
          end else begin
            state_d = S_DONE;
            err_set = 1'b1;
          end
        end
      end
      S_RUN: begin
        rd_fire  = (rd_cnt_q != len_q);
        // Last beat: all addresses issued and only the final one is left in the delay line
        run_last = !rd_fire && vld_q[RD_LAT] && (vld_q[RD_LAT-1:0] == '0);
        if (run_last) state_d = S_DONE;
      end
      S_DONE: begin
        if (!i_SoP) state_d = S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
    wr_last = (wr_cnt_q == (eff_len - 1'b1));
    onehot  = '0;
    onehot[bank_q] = 1'b1;
  end

  // Counters, address registers, valid delay line and sticky error
  always_ff @(posedge i_CLK) begin
    if (i_rst) begin
      len_q     <= '0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      bank_q    <= '0;
      cols_q    <= '0;
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      vld_q     <= '0;
      err_q     <= 1'b0;
      eop_q     <= 1'b0;
    end else begin
      wr_en_q <= '0;
      eop_q   <= 1'b0;
      vld_q   <= {vld_q[RD_LAT-1:0], rd_fire};

      if ((state_q == S_IDLE) && wr_fire) len_q <= i_imgLength;

      if (wr_fire) begin
        wr_en_q   <= onehot;
        wr_addr_q <= wr_cnt_q;
        if (wr_last) begin
          wr_cnt_q <= '0;
          bank_q   <= (bank_q == BW'(N_BANKS - 1)) ? '0 : bank_q + 1'b1;
          if (cols_q != CW'(N_BANKS)) cols_q <= cols_q + 1'b1;
        end else begin
          wr_cnt_q <= wr_cnt_q + 1'b1;
        end
      end

      // A fresh column always starts at address 0; any partial column is abandoned
      if ((state_q == S_DONE) && (state_d == S_LOAD)) wr_cnt_q <= '0;

      if ((state_q == S_LOAD) && (state_d == S_RUN)) begin
        rd_cnt_q <= '0;
      end else if (rd_fire) begin
        rd_addr_q <= rd_cnt_q;
        rd_cnt_q  <= rd_cnt_q + 1'b1;
      end

      if (err_set) begin
        err_q <= 1'b1;
        eop_q <= 1'b1;
      end
    end
  end

  assign o_wr_en      = wr_en_q;
  assign o_wr_addr    = wr_addr_q;
  assign o_rd_addr    = rd_addr_q;
  assign o_bank_ptr   = bank_q;
  assign o_conv_valid = vld_q[RD_LAT];
  // Normal completion coincides with the last valid beat; the error path uses the registered pulse
  assign o_EoP        = eop_q | run_last;
  assign o_err        = err_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_conv_col_sequencer.sv
// Directed bench for conv_col_sequencer: vector table for load/run/error flows,
// hand sequences for dropped pixels and reset in the middle of RUN.
// Outputs are sampled on the falling edge, inputs driven just after it.
module tb_conv_col_sequencer;

  logic        i_CLK = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic [10:0] i_imgLength = '0;
  logic        i_SoP = 1'b0;
  logic [3:0]  o_wr_en;
  logic [10:0] o_wr_addr;
  logic [10:0] o_rd_addr;
  logic [1:0]  o_bank_ptr;
  logic        o_conv_valid;
  logic        o_EoP;
  logic        o_err;
  logic [1:0]  o_state;

  int n_chk  = 0;
  int n_fail = 0;

  conv_col_sequencer #(.ADDR_W(11), .N_BANKS(4), .RD_LAT(2)) dut (
    .i_CLK        (i_CLK),
    .i_rst        (i_rst),
    .i_valid      (i_valid),
    .i_imgLength  (i_imgLength),
    .i_SoP        (i_SoP),
    .o_wr_en      (o_wr_en),
    .o_wr_addr    (o_wr_addr),
    .o_rd_addr    (o_rd_addr),
    .o_bank_ptr   (o_bank_ptr),
    .o_conv_valid (o_conv_valid),
    .o_EoP        (o_EoP),
    .o_err        (o_err),
    .o_state      (o_state)
  );

  always #5 i_CLK = ~i_CLK;

  typedef struct {
    logic        rst, vld, sop;
    logic [10:0] len;
    logic [3:0]  wen;
    logic [10:0] wa, ra;
    logic [1:0]  bank;
    logic        cv, eop, err;
    logic [1:0]  st;
    logic        cwa, cra;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic vl, input logic s, input logic [10:0] ln,
                     input logic [3:0] wen, input logic [10:0] wa, input logic [10:0] ra,
                     input logic [1:0] bank, input logic cv, input logic eop, input logic err,
                     input logic [1:0] st, input logic cwa, input logic cra);
    vec_t v;
    v.rst = r; v.vld = vl; v.sop = s; v.len = ln;
    v.wen = wen; v.wa = wa; v.ra = ra; v.bank = bank;
    v.cv = cv; v.eop = eop; v.err = err; v.st = st; v.cwa = cwa; v.cra = cra;
    vq.push_back(v);
  endtask

  // SoP held high through a full L=5 run and into DONE; k=0 is the SoP edge
  task automatic add_run(input logic [1:0] bank);
    for (int k = 0; k < 10; k++) begin
      add(1'b0, 1'b0, 1'b1, 11'd5, 4'b0000, 11'd0, 11'(k - 1), bank,
          (k >= 3 && k <= 7), (k == 7), 1'b0, (k >= 8) ? 2'd3 : 2'd2,
          1'b0, (k >= 1 && k <= 5));
    end
  endtask

  task automatic cyc(input logic r, input logic vl, input logic s, input logic [10:0] ln);
    i_rst = r; i_valid = vl; i_SoP = s; i_imgLength = ln;
    @(posedge i_CLK);
    @(negedge i_CLK);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  initial begin
    vec_t        v;
    logic [32:0] got, exp, msk;
    int          bound;

    // Scenario 1: reset, L=5, 15 pixels into banks 0,1,2
    add(1'b1, 1'b0, 1'b0, 11'd5, 4'b0000, 11'd0, 11'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1);
    for (int p = 0; p < 15; p++)
      add(1'b0, 1'b1, 1'b0, 11'd5, 4'(1 << (p / 5)), 11'(p % 5), 11'd0, 2'((p + 1) / 5),
          1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1);
    add(1'b0, 1'b0, 1'b0, 11'd5, 4'b0000, 11'd0, 11'd0, 2'd3, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1);
    // Scenario 2: run over banks 0..2
    add_run(2'd3);
    // Scenario 3: release SoP, load bank 3 (sliding window), pointer wraps, run again
    add(1'b0, 1'b0, 1'b0, 11'd5, 4'b0000, 11'd0, 11'd0, 2'd3, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0);
    for (int p = 0; p < 5; p++)
      add(1'b0, 1'b1, 1'b0, 11'd5, 4'b1000, 11'(p), 11'd0, (p == 4) ? 2'd0 : 2'd3,
          1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0);
    add_run(2'd0);
    add(1'b0, 1'b0, 1'b0, 11'd5, 4'b0000, 11'd0, 11'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0);
    // Scenario 4: fresh reset, L=4, only 2 columns, SoP -> error path
    add(1'b1, 1'b0, 1'b0, 11'd4, 4'b0000, 11'd0, 11'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1);
    for (int p = 0; p < 8; p++)
      add(1'b0, 1'b1, 1'b0, 11'd4, 4'(1 << (p / 4)), 11'(p % 4), 11'd0, 2'((p + 1) / 4),
          1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1);
    add(1'b0, 1'b0, 1'b1, 11'd4, 4'b0000, 11'd0, 11'd0, 2'd2, 1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 11'd4, 4'b0000, 11'd0, 11'd0, 2'd2, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 11'd4, 4'b0000, 11'd0, 11'd0, 2'd2, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 11'd4, 4'b0000, 11'd0, 11'd0, 2'd2, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1);

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      cyc(v.rst, v.vld, v.sop, v.len);
      got = {o_wr_en, o_wr_addr, o_rd_addr, o_bank_ptr, o_conv_valid, o_EoP, o_err, o_state};
      exp = {v.wen, v.wa, v.ra, v.bank, v.cv, v.eop, v.err, v.st};
      msk = {4'hF, {11{v.cwa}}, {11{v.cra}}, 2'b11, 5'b11111};
      n_chk++;
      if ((got & msk) !== (exp & msk)) begin
        n_fail++;
        $display("FAIL vec%0d: got wen=%b wa=%0d ra=%0d bank=%0d cv=%b eop=%b err=%b st=%0d, expected wen=%b wa=%0d ra=%0d bank=%0d cv=%b eop=%b err=%b st=%0d (ra_chk=%b wa_chk=%b)",
                 i, o_wr_en, o_wr_addr, o_rd_addr, o_bank_ptr, o_conv_valid, o_EoP, o_err, o_state,
                 v.wen, v.wa, v.ra, v.bank, v.cv, v.eop, v.err, v.st, v.cra, v.cwa);
      end
    end

    // Scenario 5a: zero length in IDLE ignores pixels
    cyc(1'b1, 1'b0, 1'b0, 11'd0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 11'd0);
      chk("len0_wen", 32'(o_wr_en), 32'd0);
      chk("len0_state", 32'(o_state), 32'd0);
    end
    // Scenario 5b: pixels during RUN are dropped
    for (int p = 0; p < 9; p++) cyc(1'b0, 1'b1, 1'b0, 11'd3);
    chk("pre_run_wa", 32'(o_wr_addr), 32'd2);
    cyc(1'b0, 1'b0, 1'b1, 11'd3);
    chk("run5_state", 32'(o_state), 32'd2);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b1, 1'b1, 11'd3);
      chk("run_drop_wen", 32'(o_wr_en), 32'd0);
      chk("run_drop_wa", 32'(o_wr_addr), 32'd2);
    end
    bound = 0;
    while (o_state != 2'd3 && bound < 20) begin
      cyc(1'b0, 1'b1, 1'b1, 11'd3);
      bound++;
    end
    chk("run5_reaches_done", 32'(o_state), 32'd3);

    // Scenario 6: reset sampled on the 3rd cycle of RUN
    cyc(1'b1, 1'b0, 1'b0, 11'd3);
    for (int p = 0; p < 9; p++) cyc(1'b0, 1'b1, 1'b0, 11'd3);
    cyc(1'b0, 1'b0, 1'b1, 11'd3);
    cyc(1'b0, 1'b0, 1'b1, 11'd3);
    cyc(1'b0, 1'b0, 1'b1, 11'd3);
    chk("pre_rst_state", 32'(o_state), 32'd2);
    cyc(1'b1, 1'b0, 1'b1, 11'd3);
    chk("rst_run_state", 32'(o_state), 32'd0);
    chk("rst_run_cv", 32'(o_conv_valid), 32'd0);
    chk("rst_run_bank", 32'(o_bank_ptr), 32'd0);
    chk("rst_run_eop", 32'(o_EoP), 32'd0);
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 11'd3);
      chk("post_rst_quiet", 32'({o_EoP, o_conv_valid}), 32'd0);
    end
    cyc(1'b0, 1'b1, 1'b0, 11'd3);
    chk("restart_wen", 32'(o_wr_en), 32'b0001);
    chk("restart_wa", 32'(o_wr_addr), 32'd0);
    chk("restart_state", 32'(o_state), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
